// File: rtl/mem_pkg.sv
// Shared memory-side types and default geometry for the block memory port arbiter.
package mem_pkg;

    localparam int unsigned SIZE       = 32;
    localparam int unsigned BLOCK_SIZE = 5;
    localparam int unsigned ADDR_SIZE  = 24;

    typedef logic [SIZE-1:0]            word_t;
    typedef logic [SIZE*BLOCK_SIZE-1:0] block_t;

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: rotating priority pointer plus a combinational one-hot grant.
module rr_arb #(
    parameter int unsigned N = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_gnt
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] idx;
    logic [PW:0]   sum;
    logic [N-1:0]  gnt;
    logic          found;

    // Scan from the pointer upward (mod N); the first requester wins and the pointer moves past it.
    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && i_req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_d    = (idx == PW'(N-1)) ? '0 : PW'(idx + PW'(1));
            end
        end
        if (i_rst) begin
            gnt = '0;
        end
    end

    assign o_gnt = gnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/mem_port_arb.sv
// Shares the block memory's write and read ports among NUM_REQ lanes with independent
// round-robin arbitration; read data returns registered one cycle after the grant.
module mem_port_arb
    import mem_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned SIZE       = mem_pkg::SIZE,
    parameter int unsigned BLOCK_SIZE = mem_pkg::BLOCK_SIZE,
    parameter int unsigned ADDR_SIZE  = mem_pkg::ADDR_SIZE
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic [NUM_REQ-1:0]                     i_wreq,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]           i_waddr,
    input  logic [NUM_REQ*SIZE*BLOCK_SIZE-1:0]     i_wdata,
    input  logic [NUM_REQ*$clog2(BLOCK_SIZE)-1:0]  i_wsize,
    output logic [NUM_REQ-1:0]                     o_wgnt,
    input  logic [NUM_REQ-1:0]                     i_rreq,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]           i_raddr,
    output logic [NUM_REQ-1:0]                     o_rgnt,
    output logic [NUM_REQ-1:0]                     o_rvalid,
    output logic [SIZE*BLOCK_SIZE-1:0]             o_rdata,
    output logic [ADDR_SIZE-1:0]                   o_mem_addr_w,
    output logic [SIZE*BLOCK_SIZE-1:0]             o_mem_data_w,
    output logic [$clog2(BLOCK_SIZE)-1:0]          o_mem_wr_size,
    output logic                                   o_mem_wr_en,
    output logic [ADDR_SIZE-1:0]                   o_mem_addr_r,
    input  logic [SIZE*BLOCK_SIZE-1:0]             i_mem_data
);

    localparam int unsigned BW = SIZE * BLOCK_SIZE;
    localparam int unsigned WS = $clog2(BLOCK_SIZE);

    logic [NUM_REQ-1:0] wgnt;
    logic [NUM_REQ-1:0] rgnt;

    logic [ADDR_SIZE-1:0] mem_addr_w;
    logic [BW-1:0]        mem_data_w;
    logic [WS-1:0]        mem_wr_size;
    logic [ADDR_SIZE-1:0] mem_addr_r;

    logic [NUM_REQ-1:0] rvalid_q;
    logic [NUM_REQ-1:0] rvalid_d;
    logic [BW-1:0]      rdata_q;
    logic [BW-1:0]      rdata_d;

    rr_arb #(.N(NUM_REQ)) u_warb (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_req (i_wreq),
        .o_gnt (wgnt)
    );

    rr_arb #(.N(NUM_REQ)) u_rarb (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_req (i_rreq),
        .o_gnt (rgnt)
    );

    // One-hot grant selects the winning lane's fields; idle channels drive zero.
    always_comb begin
        mem_addr_w  = '0;
        mem_data_w  = '0;
        mem_wr_size = '0;
        mem_addr_r  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (wgnt[k]) begin
                mem_addr_w  = i_waddr[k*ADDR_SIZE +: ADDR_SIZE];
                mem_data_w  = i_wdata[k*BW +: BW];
                mem_wr_size = i_wsize[k*WS +: WS];
            end
            if (rgnt[k]) begin
                mem_addr_r = i_raddr[k*ADDR_SIZE +: ADDR_SIZE];
            end
        end
    end

    // Read return: capture memory data on a grant, otherwise hold the last block.
    always_comb begin
        rvalid_d = rgnt;
        rdata_d  = (|rgnt) ? i_mem_data : rdata_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign o_wgnt        = wgnt;
    assign o_rgnt        = rgnt;
    assign o_mem_wr_en   = |wgnt;
    assign o_mem_addr_w  = mem_addr_w;
    assign o_mem_data_w  = mem_data_w;
    assign o_mem_wr_size = mem_wr_size;
    assign o_mem_addr_r  = mem_addr_r;
    assign o_rvalid      = rvalid_q;
    assign o_rdata       = rdata_q;

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb with a small behavioural block memory behind it.
module tb_mem_port_arb;
    import mem_pkg::*;

    localparam int unsigned NR = 4;
    localparam int unsigned BW = SIZE * BLOCK_SIZE;
    localparam int unsigned WS = $clog2(BLOCK_SIZE);

    logic                    i_clk = 1'b0;
    logic                    i_rst;
    logic [NR-1:0]           i_wreq;
    logic [NR*ADDR_SIZE-1:0] i_waddr;
    logic [NR*BW-1:0]        i_wdata;
    logic [NR*WS-1:0]        i_wsize;
    logic [NR-1:0]           o_wgnt;
    logic [NR-1:0]           i_rreq;
    logic [NR*ADDR_SIZE-1:0] i_raddr;
    logic [NR-1:0]           o_rgnt;
    logic [NR-1:0]           o_rvalid;
    block_t                  o_rdata;
    logic [ADDR_SIZE-1:0]    o_mem_addr_w;
    block_t                  o_mem_data_w;
    logic [WS-1:0]           o_mem_wr_size;
    logic                    o_mem_wr_en;
    logic [ADDR_SIZE-1:0]    o_mem_addr_r;
    block_t                  i_mem_data;

    logic  init_en;
    word_t mem [256];
    int    n_checks = 0;
    int    n_err    = 0;

    always #5 i_clk = ~i_clk;

    mem_port_arb #(.NUM_REQ(NR)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_wreq        (i_wreq),
        .i_waddr       (i_waddr),
        .i_wdata       (i_wdata),
        .i_wsize       (i_wsize),
        .o_wgnt        (o_wgnt),
        .i_rreq        (i_rreq),
        .i_raddr       (i_raddr),
        .o_rgnt        (o_rgnt),
        .o_rvalid      (o_rvalid),
        .o_rdata       (o_rdata),
        .o_mem_addr_w  (o_mem_addr_w),
        .o_mem_data_w  (o_mem_data_w),
        .o_mem_wr_size (o_mem_wr_size),
        .o_mem_wr_en   (o_mem_wr_en),
        .o_mem_addr_r  (o_mem_addr_r),
        .i_mem_data    (i_mem_data)
    );

    // Block memory: MSB word at the base address, writes commit at the clock edge.
    always @(posedge i_clk) begin
        if (init_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h100 + 32'(i);
        end else if (o_mem_wr_en) begin
            for (int j = 0; j < int'(BLOCK_SIZE); j++) begin
                if (j < int'(o_mem_wr_size))
                    mem[8'(o_mem_addr_w[7:0] + 8'(j))] <= o_mem_data_w[(BLOCK_SIZE-1-j)*SIZE +: SIZE];
            end
        end
    end

    always_comb begin
        i_mem_data = '0;
        for (int j = 0; j < int'(BLOCK_SIZE); j++)
            i_mem_data[(BLOCK_SIZE-1-j)*SIZE +: SIZE] = mem[8'(o_mem_addr_r[7:0] + 8'(j))];
    end

    task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_reqs();
        i_wreq  = '0;
        i_rreq  = '0;
        i_waddr = '0;
        i_raddr = '0;
        i_wdata = '0;
        i_wsize = '0;
    endtask

    task automatic set_w(input int k, input logic [ADDR_SIZE-1:0] a, input logic [WS-1:0] sz, input block_t d);
        i_wreq[k]               = 1'b1;
        i_waddr[k*ADDR_SIZE +: ADDR_SIZE] = a;
        i_wsize[k*WS +: WS]     = sz;
        i_wdata[k*BW +: BW]     = d;
    endtask

    task automatic set_r(input int k, input logic [ADDR_SIZE-1:0] a);
        i_rreq[k]                         = 1'b1;
        i_raddr[k*ADDR_SIZE +: ADDR_SIZE] = a;
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        init_en = 1'b1;
        i_rst   = 1'b1;
        clear_reqs();
        i_wreq  = '1;
        i_rreq  = '1;

        // Reset held for two edges with every request high.
        for (int c = 0; c < 2; c++) begin
            @(negedge i_clk);
            check("rst_wgnt",   BW'(o_wgnt),      BW'(0));
            check("rst_rgnt",   BW'(o_rgnt),      BW'(0));
            check("rst_rvalid", BW'(o_rvalid),    BW'(0));
            check("rst_wr_en",  BW'(o_mem_wr_en), BW'(0));
            next_cycle();
            init_en = 1'b0;
        end
        i_rst = 1'b0;

        // Fairness: all writers held for 8 cycles with zero-size writes.
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            check("fair_wgnt", BW'(o_wgnt), BW'(4'b0001 << (c % 4)));
            if (c == 0) check("first_rgnt", BW'(o_rgnt), BW'(4'b0001));
            if (c == 1) check("first_rvalid", BW'(o_rvalid), BW'(4'b0001));
            next_cycle();
            i_rreq = '0;
        end
        clear_reqs();

        // Write then read.
        set_w(0, 24'h10, 3'd3, {32'hA, 32'hB, 32'hC, 32'hD, 32'hE});
        @(negedge i_clk);
        check("wr_gnt",  BW'(o_wgnt),        BW'(4'b0001));
        check("wr_en",   BW'(o_mem_wr_en),   BW'(1));
        check("wr_addr", BW'(o_mem_addr_w),  BW'(24'h10));
        check("wr_size", BW'(o_mem_wr_size), BW'(3));
        check("wr_data", o_mem_data_w,       {32'hA, 32'hB, 32'hC, 32'hD, 32'hE});
        next_cycle();
        clear_reqs();
        set_r(1, 24'h10);
        @(negedge i_clk);
        check("rd_gnt",  BW'(o_rgnt),       BW'(4'b0010));
        check("rd_addr", BW'(o_mem_addr_r), BW'(24'h10));
        next_cycle();
        clear_reqs();
        @(negedge i_clk);
        check("rd_valid", BW'(o_rvalid),    BW'(4'b0010));
        check("rd_data",  o_rdata,          {32'hA, 32'hB, 32'hC, 32'h113, 32'h114});
        check("idle_wr_en", BW'(o_mem_wr_en), BW'(0));
        next_cycle();
        @(negedge i_clk);
        check("rvalid_pulse", BW'(o_rvalid), BW'(0));
        check("rdata_hold",   o_rdata,       {32'hA, 32'hB, 32'hC, 32'h113, 32'h114});

        // Hazard: seed mem[0x20]=1, then write 5 and read the same address together.
        next_cycle();
        set_w(2, 24'h20, 3'd1, {32'h1, 32'h0, 32'h0, 32'h0, 32'h0});
        @(negedge i_clk);
        check("hz_seed_gnt", BW'(o_wgnt), BW'(4'b0100));
        next_cycle();
        clear_reqs();
        set_w(2, 24'h20, 3'd1, {32'h5, 32'h0, 32'h0, 32'h0, 32'h0});
        set_r(3, 24'h20);
        @(negedge i_clk);
        check("hz_wgnt", BW'(o_wgnt), BW'(4'b0100));
        check("hz_rgnt", BW'(o_rgnt), BW'(4'b1000));
        next_cycle();
        clear_reqs();
        set_r(3, 24'h20);
        @(negedge i_clk);
        check("hz_old_valid", BW'(o_rvalid), BW'(4'b1000));
        check("hz_old_data",  o_rdata, {32'h1, 32'h121, 32'h122, 32'h123, 32'h124});
        check("hz_reread_gnt", BW'(o_rgnt), BW'(4'b1000));
        next_cycle();
        clear_reqs();
        @(negedge i_clk);
        check("hz_new_data", o_rdata, {32'h5, 32'h121, 32'h122, 32'h123, 32'h124});

        // Concurrency, with a zero-size write that must leave memory untouched.
        next_cycle();
        set_w(0, 24'h30, 3'd0, {32'hFF, 32'hFF, 32'hFF, 32'hFF, 32'hFF});
        set_r(3, 24'h40);
        @(negedge i_clk);
        check("cc_wgnt",  BW'(o_wgnt),      BW'(4'b0001));
        check("cc_rgnt",  BW'(o_rgnt),      BW'(4'b1000));
        check("cc_wr_en", BW'(o_mem_wr_en), BW'(1));
        next_cycle();
        clear_reqs();
        set_r(1, 24'h30);
        @(negedge i_clk);
        check("cc_rvalid", BW'(o_rvalid), BW'(4'b1000));
        check("cc_rdata",  o_rdata, {32'h140, 32'h141, 32'h142, 32'h143, 32'h144});
        check("z_rgnt",    BW'(o_rgnt),   BW'(4'b0010));
        next_cycle();
        clear_reqs();
        @(negedge i_clk);
        check("z_rdata", o_rdata, {32'h130, 32'h131, 32'h132, 32'h133, 32'h134});

        // Mid-operation reset: read pointer sits at 2 here; reset must pull it back to 0.
        next_cycle();
        i_rst = 1'b1;
        set_r(2, 24'h10);
        @(negedge i_clk);
        check("mr_rgnt", BW'(o_rgnt), BW'(0));
        next_cycle();
        i_rst = 1'b0;
        clear_reqs();
        set_r(1, 24'h50);
        set_r(2, 24'h60);
        @(negedge i_clk);
        check("mr_rvalid", BW'(o_rvalid), BW'(0));
        check("mr_rgnt2",  BW'(o_rgnt),   BW'(4'b0010));
        next_cycle();
        clear_reqs();
        @(negedge i_clk);
        check("mr_rvalid2", BW'(o_rvalid), BW'(4'b0010));
        check("mr_rdata",   o_rdata, {32'h150, 32'h151, 32'h152, 32'h153, 32'h154});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
